overlap_frame_scheduler: RTL and testbench

- Parametrised successor to the fixed 4-FFT, 1024-point, 50%-overlap ADC write-enable generator.
- Routes each valid ADC sample to every FFT instance whose analysis window is open.
- Per instance it supplies a write address and frame start/last markers.
- It respects each instance's ready flag, caps frames per acquisition block, and counts dropped frames.
- Sits between the ADC sample interface and the bank of FFT input buffers.

---
 rtl/overlap_frame_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_overlap_frame_scheduler.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/overlap_frame_scheduler.sv
// Purpose: routes each ADC sample into every overlapping FFT analysis window, with per-instance address and frame markers.
// Latency: every output is registered and describes the valid sample taken on the previous clock edge (1 cycle).
// Backpressure: a start due on a not-ready instance is dropped, counted and flagged; frames already in flight always complete.
module overlap_frame_scheduler #(
    parameter int SAMPLE_W         = 12,
    parameter int FFT_SIZE         = 1024,
    parameter int HOP              = 512,
    parameter int NUM_FFT          = 4,
    parameter int BLOCK_SAMPLES    = 25000,
    parameter int FRAMES_PER_BLOCK = 47,
    parameter int ADDR_W           = $clog2(FFT_SIZE)
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_adc_input_valid,
    input  logic [SAMPLE_W-1:0]         i_adc_data,
    input  logic [NUM_FFT-1:0]          i_fft_ready,
    output logic [NUM_FFT-1:0]          o_wr_en,
    output logic [NUM_FFT*ADDR_W-1:0]   o_wr_addr,
    output logic [SAMPLE_W-1:0]         o_wr_data,
    output logic [NUM_FFT-1:0]          o_frame_start,
    output logic [NUM_FFT-1:0]          o_frame_last,
    output logic                        o_overrun,
    output logic [15:0]                 o_dropped_count,
    output logic                        o_block_done
);

    localparam int HOP_W     = (HOP > 1) ? $clog2(HOP) : 1;
    localparam int BLK_W     = (BLOCK_SAMPLES > 1) ? $clog2(BLOCK_SAMPLES) : 1;
    localparam int STARTED_W = $clog2(FRAMES_PER_BLOCK + 1);
    localparam int CH_W      = (NUM_FFT > 1) ? $clog2(NUM_FFT) : 1;

    localparam logic [HOP_W-1:0]     HOP_LAST    = HOP_W'(HOP - 1);
    localparam logic [BLK_W-1:0]     BLK_LAST    = BLK_W'(BLOCK_SAMPLES - 1);
    localparam logic [STARTED_W-1:0] STARTED_MAX = STARTED_W'(FRAMES_PER_BLOCK);
    localparam logic [CH_W-1:0]      CH_LAST     = CH_W'(NUM_FFT - 1);
    localparam logic [ADDR_W-1:0]    ADDR_LAST   = ADDR_W'(FFT_SIZE - 1);
    localparam logic [15:0]          DROP_MAX    = 16'hFFFF;

    // Round-robin reuse of an instance is only safe if its previous frame has ended
    // before the instance comes round again; reject configurations that break this.
    generate
        if (NUM_FFT * HOP < FFT_SIZE) begin : g_bad_overlap
            $error("overlap_frame_scheduler: NUM_FFT*HOP must be >= FFT_SIZE");
        end
        if (FFT_SIZE < 2 || (FFT_SIZE & (FFT_SIZE - 1)) != 0) begin : g_bad_size
            $error("overlap_frame_scheduler: FFT_SIZE must be a power of two >= 2");
        end
        if (HOP < 1 || NUM_FFT < 1 || BLOCK_SAMPLES < 2) begin : g_bad_basic
            $error("overlap_frame_scheduler: HOP, NUM_FFT must be >= 1 and BLOCK_SAMPLES >= 2");
        end
        if (FRAMES_PER_BLOCK < 1 || (FRAMES_PER_BLOCK - 1) * HOP >= BLOCK_SAMPLES) begin : g_bad_budget
            $error("overlap_frame_scheduler: FRAMES_PER_BLOCK starts must fit inside BLOCK_SAMPLES");
        end
    endgenerate

    // Sequencing state: position within hop and block, frames started this block, next target instance.
    logic [HOP_W-1:0]     r_hop_cnt;
    logic [BLK_W-1:0]     r_block_cnt;
    logic [STARTED_W-1:0] r_started;
    logic [CH_W-1:0]      r_next_ch;
    logic [15:0]          r_dropped;

    // Per-instance frame state.
    logic [NUM_FFT-1:0]   r_active;
    logic [ADDR_W-1:0]    r_addr [NUM_FFT];

    // Registered outputs.
    logic [NUM_FFT-1:0]        r_wr_en;
    logic [NUM_FFT*ADDR_W-1:0] r_wr_addr;
    logic [SAMPLE_W-1:0]       r_wr_data;
    logic [NUM_FFT-1:0]        r_frame_start;
    logic [NUM_FFT-1:0]        r_frame_last;
    logic                      r_overrun;
    logic                      r_block_done;

    // Decisions for the current sample.
    logic                 w_start_due;
    logic                 w_target_rdy;
    logic                 w_drop;
    logic [NUM_FFT-1:0]   w_start_vec;
    logic [NUM_FFT-1:0]   w_wr_en;
    logic [NUM_FFT-1:0]   w_last;
    logic [ADDR_W-1:0]    w_addr [NUM_FFT];
    logic                 w_block_wrap;
    logic                 w_hop_wrap;
    logic [CH_W-1:0]      w_next_ch_inc;

    // Decide whether a frame starts or is dropped on this sample, and which instances write where.
    always_comb begin
        w_start_due   = 1'b0;
        w_target_rdy  = 1'b0;
        w_drop        = 1'b0;
        w_start_vec   = '0;
        w_wr_en       = '0;
        w_last        = '0;
        w_block_wrap  = (r_block_cnt == BLK_LAST);
        w_hop_wrap    = (r_hop_cnt == HOP_LAST);
        w_next_ch_inc = (r_next_ch == CH_LAST) ? '0 : r_next_ch + CH_W'(1);
        for (int i = 0; i < NUM_FFT; i++) begin
            w_addr[i] = '0;
        end

        w_start_due  = (r_hop_cnt == '0) && i_enable && (r_started < STARTED_MAX);
        w_target_rdy = i_fft_ready[r_next_ch];
        if (w_start_due && w_target_rdy) begin
            w_start_vec[r_next_ch] = 1'b1;
        end
        w_drop = w_start_due && !w_target_rdy;

        // A freshly started instance writes address 0 on the same sample as its start.
        for (int i = 0; i < NUM_FFT; i++) begin
            w_wr_en[i] = r_active[i] | w_start_vec[i];
            w_addr[i]  = w_start_vec[i] ? '0 : r_addr[i];
            w_last[i]  = w_wr_en[i] && (w_addr[i] == ADDR_LAST);
        end
    end

    // Hop/block position, per-block start budget, round-robin pointer and drop counter.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_hop_cnt   <= '0;
            r_block_cnt <= '0;
            r_started   <= '0;
            r_next_ch   <= '0;
            r_dropped   <= '0;
        end else if (i_adc_input_valid) begin
            // The block wrap realigns the hop grid and refills the start budget for the next sample.
            if (w_block_wrap) begin
                r_block_cnt <= '0;
                r_hop_cnt   <= '0;
                r_started   <= '0;
            end else begin
                r_block_cnt <= r_block_cnt + BLK_W'(1);
                r_hop_cnt   <= w_hop_wrap ? '0 : r_hop_cnt + HOP_W'(1);
                if (w_start_due && w_target_rdy) begin
                    r_started <= r_started + STARTED_W'(1);
                end
            end
            // The pointer moves on every due start, taken or dropped, so instances keep their slot.
            if (w_start_due) begin
                r_next_ch <= w_next_ch_inc;
            end
            if (w_drop && (r_dropped != DROP_MAX)) begin
                r_dropped <= r_dropped + 16'd1;
            end
        end
    end

    // Per-instance frame progress: activate on start, step the address, retire after the last word.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_active <= '0;
            for (int i = 0; i < NUM_FFT; i++) begin
                r_addr[i] <= '0;
            end
        end else if (i_adc_input_valid) begin
            for (int i = 0; i < NUM_FFT; i++) begin
                if (w_wr_en[i]) begin
                    if (w_last[i]) begin
                        r_active[i] <= 1'b0;
                        r_addr[i]   <= '0;
                    end else begin
                        r_active[i] <= 1'b1;
                        r_addr[i]   <= w_addr[i] + ADDR_W'(1);
                    end
                end
            end
        end
    end

    // Output register: strobes describe the previous valid sample and are cleared on idle cycles.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_en       <= '0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_frame_start <= '0;
            r_frame_last  <= '0;
            r_overrun     <= 1'b0;
            r_block_done  <= 1'b0;
        end else if (i_adc_input_valid) begin
            r_wr_en       <= w_wr_en;
            r_wr_data     <= i_adc_data;
            r_frame_start <= w_start_vec;
            r_frame_last  <= w_last;
            r_overrun     <= w_drop;
            r_block_done  <= w_block_wrap;
            for (int i = 0; i < NUM_FFT; i++) begin
                r_wr_addr[i*ADDR_W +: ADDR_W] <= w_addr[i];
            end
        end else begin
            r_wr_en       <= '0;
            r_frame_start <= '0;
            r_frame_last  <= '0;
            r_overrun     <= 1'b0;
            r_block_done  <= 1'b0;
        end
    end

    assign o_wr_en         = r_wr_en;
    assign o_wr_addr       = r_wr_addr;
    assign o_wr_data       = r_wr_data;
    assign o_frame_start   = r_frame_start;
    assign o_frame_last    = r_frame_last;
    assign o_overrun       = r_overrun;
    assign o_dropped_count = r_dropped;
    assign o_block_done    = r_block_done;

endmodule

// File: tb/tb_overlap_frame_scheduler.sv
// Bench for overlap_frame_scheduler: default configuration plus a small configuration.
// Frames are modelled as start timestamps; address = sample index - frame start.
// Outputs are compared against the model on every falling edge, plus literal pins.
module tb_overlap_frame_scheduler;

    localparam int AW0 = 10;
    localparam int AW1 = 3;

    localparam int P_FS [2]  = '{1024, 8};
    localparam int P_HOP[2]  = '{512, 4};
    localparam int P_NF [2]  = '{4, 3};
    localparam int P_BS [2]  = '{25000, 20};
    localparam int P_FPB[2]  = '{47, 3};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // Default-configuration DUT signals.
    logic             en0 = 1'b0, v0 = 1'b0;
    logic [11:0]      d0 = '0;
    logic [3:0]       rdy0 = '0;
    logic [3:0]       o_wr_en0, o_frame_start0, o_frame_last0;
    logic [4*AW0-1:0] o_wr_addr0;
    logic [11:0]      o_wr_data0;
    logic             o_overrun0, o_block_done0;
    logic [15:0]      o_dropped_count0;

    // Small-configuration DUT signals.
    logic             en1 = 1'b0, v1 = 1'b0;
    logic [11:0]      d1 = '0;
    logic [2:0]       rdy1 = '0;
    logic [2:0]       o_wr_en1, o_frame_start1, o_frame_last1;
    logic [3*AW1-1:0] o_wr_addr1;
    logic [11:0]      o_wr_data1;
    logic             o_overrun1, o_block_done1;
    logic [15:0]      o_dropped_count1;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    always #5 clk = ~clk;

    overlap_frame_scheduler dut0 (
        .i_clk(clk), .i_reset(rst_n), .i_enable(en0), .i_adc_input_valid(v0),
        .i_adc_data(d0), .i_fft_ready(rdy0),
        .o_wr_en(o_wr_en0), .o_wr_addr(o_wr_addr0), .o_wr_data(o_wr_data0),
        .o_frame_start(o_frame_start0), .o_frame_last(o_frame_last0),
        .o_overrun(o_overrun0), .o_dropped_count(o_dropped_count0), .o_block_done(o_block_done0)
    );

    overlap_frame_scheduler #(
        .SAMPLE_W(12), .FFT_SIZE(8), .HOP(4), .NUM_FFT(3),
        .BLOCK_SAMPLES(20), .FRAMES_PER_BLOCK(3)
    ) dut1 (
        .i_clk(clk), .i_reset(rst_n), .i_enable(en1), .i_adc_input_valid(v1),
        .i_adc_data(d1), .i_fft_ready(rdy1),
        .o_wr_en(o_wr_en1), .o_wr_addr(o_wr_addr1), .o_wr_data(o_wr_data1),
        .o_frame_start(o_frame_start1), .o_frame_last(o_frame_last1),
        .o_overrun(o_overrun1), .o_dropped_count(o_dropped_count1), .o_block_done(o_block_done1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_n      [2];
    int          m_blkpos [2];
    int          m_started[2];
    int          m_next   [2];
    int          m_dropped[2];
    int          m_chstart[2][4];
    logic [3:0]  e_wr_en  [2];
    logic [3:0]  e_start  [2];
    logic [3:0]  e_last   [2];
    int          e_addr   [2][4];
    logic        e_ovr    [2];
    logic        e_bd     [2];
    int          e_dc     [2];
    logic [11:0] e_data   [2];

    task automatic model_reset(input int k);
        m_n[k] = 0; m_blkpos[k] = 0; m_started[k] = 0; m_next[k] = 0; m_dropped[k] = 0;
        for (int c = 0; c < 4; c++) begin
            m_chstart[k][c] = -1;
            e_addr[k][c] = 0;
        end
        e_wr_en[k] = '0; e_start[k] = '0; e_last[k] = '0;
        e_ovr[k] = 1'b0; e_bd[k] = 1'b0; e_dc[k] = 0; e_data[k] = '0;
    endtask

    task automatic model_idle(input int k);
        e_wr_en[k] = '0; e_start[k] = '0; e_last[k] = '0;
        e_ovr[k] = 1'b0; e_bd[k] = 1'b0;
    endtask

    task automatic model_step(input int k, input logic en, input logic [3:0] rdy, input logic [11:0] data);
        int ch;
        model_idle(k);
        // Frame starts fall on the hop grid measured from the block start.
        if ((m_blkpos[k] % P_HOP[k]) == 0 && en && m_started[k] < P_FPB[k]) begin
            ch = m_next[k];
            if (rdy[ch]) begin
                m_chstart[k][ch] = m_n[k];
                e_start[k][ch]   = 1'b1;
                m_started[k]++;
            end else begin
                e_ovr[k] = 1'b1;
                if (m_dropped[k] < 65535) m_dropped[k]++;
            end
            m_next[k] = (ch + 1) % P_NF[k];
        end
        for (int c = 0; c < P_NF[k]; c++) begin
            if (m_chstart[k][c] >= 0) begin
                e_wr_en[k][c] = 1'b1;
                e_addr[k][c]  = m_n[k] - m_chstart[k][c];
                if (e_addr[k][c] == P_FS[k] - 1) begin
                    e_last[k][c]     = 1'b1;
                    m_chstart[k][c] = -1;
                end
            end
        end
        e_bd[k] = (m_blkpos[k] == P_BS[k] - 1);
        if (e_bd[k]) begin
            m_blkpos[k]  = 0;
            m_started[k] = 0;
        end else begin
            m_blkpos[k]++;
        end
        m_n[k]++;
        e_dc[k]   = m_dropped[k];
        e_data[k] = data;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset(0);
            model_reset(1);
        end else begin
            if (v0) model_step(0, en0, rdy0, d0); else model_idle(0);
            if (v1) model_step(1, en1, {1'b0, rdy1}, d1); else model_idle(1);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("d0_wr_en",    32'(o_wr_en0),        32'(e_wr_en[0]));
            chk("d0_start",    32'(o_frame_start0),  32'(e_start[0]));
            chk("d0_last",     32'(o_frame_last0),   32'(e_last[0]));
            chk("d0_overrun",  32'(o_overrun0),      32'(e_ovr[0]));
            chk("d0_blkdone",  32'(o_block_done0),   32'(e_bd[0]));
            chk("d0_dropped",  32'(o_dropped_count0), e_dc[0]);
            chk("d0_wr_data",  32'(o_wr_data0),      32'(e_data[0]));
            for (int c = 0; c < 4; c++)
                if (e_wr_en[0][c]) chk("d0_addr", 32'(o_wr_addr0[c*AW0 +: AW0]), e_addr[0][c]);
            chk("d1_wr_en",    32'(o_wr_en1),        32'(e_wr_en[1]));
            chk("d1_start",    32'(o_frame_start1),  32'(e_start[1]));
            chk("d1_last",     32'(o_frame_last1),   32'(e_last[1]));
            chk("d1_overrun",  32'(o_overrun1),      32'(e_ovr[1]));
            chk("d1_blkdone",  32'(o_block_done1),   32'(e_bd[1]));
            chk("d1_dropped",  32'(o_dropped_count1), e_dc[1]);
            chk("d1_wr_data",  32'(o_wr_data1),      32'(e_data[1]));
            for (int c = 0; c < 3; c++)
                if (e_wr_en[1][c]) chk("d1_addr", 32'(o_wr_addr1[c*AW1 +: AW1]), e_addr[1][c]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic s0(input logic en, input logic [3:0] rdy);
        en0 = en; rdy0 = rdy; d0 = 12'($urandom); v0 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic s1(input logic en, input logic [2:0] rdy);
        en1 = en; rdy1 = rdy; d1 = 12'($urandom); v1 = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        v0 = 1'b0; v1 = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        v0 = 1'b0; v1 = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",   32'(o_wr_en0),         0);
        chk("rst_addr",    32'(o_wr_addr0[31:0]), 0);
        chk("rst_data",    32'(o_wr_data0),       0);
        chk("rst_dropped", 32'(o_dropped_count0), 0);
        chk("rst_d1_wr",   32'(o_wr_en1),         0);
        rst_n = 1'b1;
        cmp_on = 1'b1;
    endtask

    initial begin
        int two;

        // A: defaults, enable, all ready, 2048 samples.
        do_reset();
        two = 0;
        for (int n = 0; n < 2048; n++) begin
            s0(1'b1, 4'hF);
            if (n == 0 || n == 512 || n == 1024 || n == 1536)
                chk("A_start", 32'(o_frame_start0), 1 << (n / 512));
            if (n == 1023) begin
                chk("A_last_ch0", 32'(o_frame_last0), 1);
                chk("A_addr_ch0", 32'(o_wr_addr0[AW0-1:0]), 1023);
            end
            if (n >= 512 && $countones(o_wr_en0) == 2) two++;
        end
        chk("A_two_writers", two, 1536);

        // C: instance 1 not ready at sample 512.
        do_reset();
        for (int n = 0; n < 1030; n++) begin
            s0(1'b1, (n == 512) ? 4'b1101 : 4'hF);
            if (n == 512) begin
                chk("C_overrun", 32'(o_overrun0), 1);
                chk("C_dropped", 32'(o_dropped_count0), 1);
                chk("C_no_start", 32'(o_frame_start0), 0);
            end
            if (n == 1024) chk("C_start_ch2", 32'(o_frame_start0), 4);
        end

        // D: enable low over samples 500..600.
        do_reset();
        for (int n = 0; n < 1100; n++) begin
            s0((n >= 500 && n <= 600) ? 1'b0 : 1'b1, 4'hF);
            if (n == 512) begin
                chk("D_no_start", 32'(o_frame_start0), 0);
                chk("D_no_overrun", 32'(o_overrun0), 0);
            end
            if (n == 1023) chk("D_last_ch0", 32'(o_frame_last0), 1);
            if (n == 1024) chk("D_start_ch1", 32'(o_frame_start0), 2);
        end

        // E: one strobe per 7 cycles.
        do_reset();
        s0(1'b1, 4'hF);
        chk("E_first_start", 32'(o_frame_start0), 1);
        idle(1);
        chk("E_gap_start", 32'(o_frame_start0), 0);
        chk("E_gap_wr_en", 32'(o_wr_en0), 0);
        idle(5);
        for (int n = 1; n < 40; n++) begin
            s0(1'b1, 4'hF);
            idle(6);
        end

        // F: async reset between edges at sample 700.
        do_reset();
        for (int n = 0; n < 700; n++) s0(1'b1, 4'hF);
        v0 = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("F_rst_wr_en", 32'(o_wr_en0), 0);
        chk("F_rst_addr",  32'(o_wr_addr0[31:0]), 0);
        chk("F_rst_data",  32'(o_wr_data0), 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        s0(1'b1, 4'hF);
        chk("F_restart", 32'(o_frame_start0), 1);
        chk("F_restart_wr", 32'(o_wr_en0), 1);
        chk("F_restart_addr", 32'(o_wr_addr0[AW0-1:0]), 0);
        idle(1);

        // B: small configuration, block boundary and frame budget.
        do_reset();
        for (int n = 0; n < 45; n++) begin
            s1(1'b1, 3'b111);
            if (n == 0 || n == 4 || n == 8) chk("B_start", 32'(o_frame_start1), 1 << (n / 4));
            if (n == 7) begin
                chk("B_last_ch0", 32'(o_frame_last1), 1);
                chk("B_addr_ch0", 32'(o_wr_addr1[AW1-1:0]), 7);
            end
            if (n == 12 || n == 16) chk("B_budget", 32'(o_frame_start1), 0);
            if (n == 19) chk("B_block_done", 32'(o_block_done1), 1);
            if (n == 20) chk("B_next_block", 32'(o_frame_start1), 1);
            if (n == 24) chk("B_next_ch1", 32'(o_frame_start1), 2);
            if (n == 39) chk("B_block_done2", 32'(o_block_done1), 1);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
